cv32e40p_alu_ft_reconf_ctrl: RTL and testbench
==============================================

Name: cv32e40p_alu_ft_reconf_ctrl

Overview:
Reconfiguration controller that drives the fault-tolerant ALU's replica-selection side. It consumes the per-ALU permanent-fault triggers and the ALU ready signal. It produces the 3-bit mux select, the per-replica input clock enables and the used-ALU mask. When an active replica is declared permanently faulty, it swaps in the standby replica under a stall/drain/warm-up handshake. It sits in the EX stage next to the FT ALU and feeds the hazard/stall logic.

Parameters:
WARMUP_CYCLES, 1, cycles the standby replica is clocked, under stall, before it is switched into the voter (1..15).
ROTATE_PERIOD, 1024, cycles between standby rotations; used only with the optional feature.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
faulty_pulse_i  in  4  one-cycle pulse per ALU, from that ALU's error counter, when it is declared permanently faulty
alu_ready_i  in  1  voted ALU ready; 0 while a multicycle op (div/rem) is in progress
sel_mux_ex_o  out  3  bit k=1 selects ALU k for voter input k; bit k=0 selects ALU 3
clock_en_o  out  4  input-pipe clock enable per ALU
used_alu_o  out  4  one-hot-complement mask of the ALUs feeding the voter
faulty_mask_o  out  4  sticky per-ALU permanent-fault flags
reconf_stall_o  out  1  stall request to the pipeline during a swap
degraded_o  out  1  sticky; no healthy spare remains
fatal_o  out  1  sticky; two or more faulty ALUs in the active set

Behaviour:
- Clock and reset: one clock. rst_n is asynchronous, active-low. All state is async-cleared.
- Reset values: standby=3, sel_mux_ex_o=3'b111, used_alu_o=4'b0111, clock_en_o=4'b0111, faulty_mask_o=0, reconf_stall_o=0, degraded_o=0, fatal_o=0, state=NORMAL.
- Configuration map (registered), from standby index s:
  - s=3: sel=111, used=0111.
  - s=0: sel=110, used=1110.
  - s=1: sel=101, used=1101.
  - s=2: sel=011, used=1011.
  - clock_en = used, except in WARMUP, where it is used | (1<<new_standby_src).
- Fault filter: pulses for ALUs already set in faulty_mask_o are ignored. Every other pulse sets its faulty_mask bit on the next edge, in every state.
- FSM states: NORMAL, DRAIN, WARMUP, DEGRADED, FATAL.
- NORMAL:
  - New fault on exactly one active ALU, with the standby healthy: go to DRAIN and latch victim=k.
  - New fault on the standby only: go to DEGRADED and hold the configuration.
  - Two or more new faults in the same cycle, with at least one on an active ALU: go to FATAL.
- DRAIN: reconf_stall_o=1. Stay while alu_ready_i=0. When alu_ready_i=1, go to WARMUP and load the warm-up counter with WARMUP_CYCLES.
- WARMUP:
  - reconf_stall_o=1; the standby clock is enabled; the counter decrements each cycle.
  - When the counter reaches 0: standby becomes victim, and sel/used/clock_en update in the same edge. Go to DEGRADED. reconf_stall_o deasserts in the next cycle.
  - Any new fault seen in DRAIN/WARMUP is evaluated at the swap: if the post-swap active set contains a faulty ALU, go to FATAL instead.
- Total swap stall: drain cycles + WARMUP_CYCLES + 1.
- DEGRADED: degraded_o=1. Any new fault on an active ALU goes to FATAL. The spare is gated off; a fault pulse on it only updates the mask.
- FATAL: fatal_o=1 and degraded_o=1. The configuration is frozen and reconf_stall_o=0. The state is exited only by reset.
- Reset mid-swap: async return to the reset configuration. faulty_mask_o is cleared (the mask is not retained).

Optional Feature:
CV32E40P_FT_ALU_ROTATE_EN:
- Defined: in NORMAL, a free-running counter counts to ROTATE_PERIOD-1. On wrap, the controller rotates the standby to the next healthy index (3→0→1→2→3), using the same DRAIN/WARMUP path with victim=next index. The state returns to NORMAL, not DEGRADED.
- Rotation is suppressed once any faulty_mask bit is set. The counter is reset on each swap.
- Undefined: no counter is present, and the standby changes only on a fault.

Decomposition:
- Shared package (cv32e40p_pkg):
  - ft_reconf_state_e enum.
  - FT_STBY_W=2 constant.
  - Function ft_stby_to_sel(idx), returning the 3-bit select.
  - Function ft_stby_to_used(idx), returning the 4-bit mask.
- One natural sub-module: cv32e40p_ft_warmup_cnt, a loadable down-counter with a zero flag (shared with the rotation counter when the feature is enabled).

Test Plan:
- Reset → sel=111, used=0111, clock_en=0111, all flags 0.
- faulty_pulse_i=0001 with alu_ready_i=1, WARMUP_CYCLES=1:
  - stall high for 2 cycles; clock_en=1111 during WARMUP.
  - Then sel=110, used=1110, clock_en=1110, degraded_o=1.
- faulty_pulse_i=0010 with alu_ready_i=0 for 5 cycles → stall stays high through DRAIN; the swap completes 2 cycles after ready rises; sel=101.
- After the first swap, faulty_pulse_i=0100 → fatal_o=1, configuration frozen, stall=0.
- faulty_pulse_i=0011 in a single cycle → FATAL directly, with no swap.
- With CV32E40P_FT_ALU_ROTATE_EN and ROTATE_PERIOD=16 → the standby cycles 3→0→1 every 16 cycles plus the swap stall; rotation stops after any fault pulse.

Source files
------------

// File: rtl/cv32e40p_alu_ft_reconf_ctrl_pkg.sv
// Shared types and helpers for the fault-tolerant ALU reconfiguration controller.
//   ft_reconf_state_e : controller FSM states
//   FT_STBY_W         : width of a standby / replica index
//   ft_stby_to_sel    : standby index -> 3-bit voter mux select
//   ft_stby_to_used   : standby index -> 4-bit used-ALU mask
package cv32e40p_pkg;

    localparam int unsigned FT_STBY_W = 2;

    typedef enum logic [2:0] {
        FT_NORMAL,
        FT_DRAIN,
        FT_WARMUP,
        FT_DEGRADED,
        FT_FATAL
    } ft_reconf_state_e;

    // Voter input k takes ALU k unless ALU k is the standby, in which case ALU 3 stands in.
    function automatic logic [2:0] ft_stby_to_sel(input logic [FT_STBY_W-1:0] idx);
        logic [2:0] sel;
        case (idx)
            2'd0:    sel = 3'b110;
            2'd1:    sel = 3'b101;
            2'd2:    sel = 3'b011;
            default: sel = 3'b111;
        endcase
        return sel;
    endfunction

    function automatic logic [3:0] ft_stby_to_used(input logic [FT_STBY_W-1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/cv32e40p_alu_ft_reconf_ctrl_warmup_cnt.sv
// cv32e40p_ft_warmup_cnt: loadable down-counter with a zero flag.
//   clk, rst_n   : clock, asynchronous active-low reset (count -> RESET_VAL)
//   load_i       : load load_val_i (has priority over dec_i)
//   load_val_i   : value to load
//   dec_i        : decrement by one (saturates at zero)
//   zero_o       : high in the cycle whose decrement brings the count to zero
module cv32e40p_ft_warmup_cnt #(
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= CNT_W'(RESET_VAL);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/cv32e40p_alu_ft_reconf_ctrl.sv
// Reconfiguration controller for the triple-voted FT ALU with one standby replica.
// Swaps the standby in for a permanently faulty active replica through a
// stall / drain / warm-up handshake.
//   faulty_pulse_i  : per-ALU permanent-fault pulse
//   alu_ready_i     : voted ALU ready (0 during multicycle ops)
//   sel_mux_ex_o    : voter mux select, clock_en_o : per-ALU input clock enable
//   used_alu_o      : ALUs feeding the voter, faulty_mask_o : sticky fault flags
//   reconf_stall_o  : pipeline stall during a swap
//   degraded_o      : no healthy spare, fatal_o : faulty ALU in the active set
// Optional macro CV32E40P_FT_ALU_ROTATE_EN: periodic standby rotation while fault-free.
module cv32e40p_alu_ft_reconf_ctrl
    import cv32e40p_pkg::*;
#(
    parameter int unsigned WARMUP_CYCLES = 1,
    parameter int unsigned ROTATE_PERIOD = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] faulty_pulse_i,
    input  logic       alu_ready_i,
    output logic [2:0] sel_mux_ex_o,
    output logic [3:0] clock_en_o,
    output logic [3:0] used_alu_o,
    output logic [3:0] faulty_mask_o,
    output logic       reconf_stall_o,
    output logic       degraded_o,
    output logic       fatal_o
);

    localparam int unsigned CNT_MAX = (ROTATE_PERIOD > WARMUP_CYCLES) ? ROTATE_PERIOD : WARMUP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
`ifdef CV32E40P_FT_ALU_ROTATE_EN
    localparam int unsigned CNT_RST = ROTATE_PERIOD;
`else
    localparam int unsigned CNT_RST = 0;
`endif

    ft_reconf_state_e     state_q, state_d;
    logic [FT_STBY_W-1:0] stby_q, stby_d;
    logic [FT_STBY_W-1:0] victim_q, victim_d;
    logic [2:0]           sel_q, sel_d;
    logic [3:0]           used_q, used_d;
    logic [3:0]           clk_en_q, clk_en_d;
    logic [3:0]           mask_q, mask_d;
`ifdef CV32E40P_FT_ALU_ROTATE_EN
    logic                 rot_q, rot_d;
`endif

    logic [3:0]       new_fault;
    logic [3:0]       new_active;
    logic [3:0]       post_used;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero;

    cv32e40p_ft_warmup_cnt #(
        .CNT_W    (CNT_W),
        .RESET_VAL(CNT_RST)
    ) u_warmup_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (cnt_load),
        .load_val_i(cnt_load_val),
        .dec_i     (cnt_dec),
        .zero_o    (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FT_NORMAL;
            stby_q   <= 2'd3;
            victim_q <= 2'd3;
            sel_q    <= 3'b111;
            used_q   <= 4'b0111;
            clk_en_q <= 4'b0111;
            mask_q   <= '0;
`ifdef CV32E40P_FT_ALU_ROTATE_EN
            rot_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            stby_q   <= stby_d;
            victim_q <= victim_d;
            sel_q    <= sel_d;
            used_q   <= used_d;
            clk_en_q <= clk_en_d;
            mask_q   <= mask_d;
`ifdef CV32E40P_FT_ALU_ROTATE_EN
            rot_q    <= rot_d;
`endif
        end
    end

    always_comb begin
        new_fault    = faulty_pulse_i & ~mask_q;
        new_active   = new_fault & used_q;
        mask_d       = mask_q | new_fault;
        post_used    = ft_stby_to_used(victim_q);
        state_d      = state_q;
        stby_d       = stby_q;
        victim_d     = victim_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
`ifdef CV32E40P_FT_ALU_ROTATE_EN
        rot_d        = rot_q;
`endif
        case (state_q)
            FT_NORMAL: begin
`ifdef CV32E40P_FT_ALU_ROTATE_EN
                if (cnt_zero) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(ROTATE_PERIOD);
                end else begin
                    cnt_dec = 1'b1;
                end
`endif
                if ((new_active != '0) && ($countones(new_fault) > 1)) begin
                    state_d = FT_FATAL;
                end else if (new_active != '0) begin
                    if (mask_q[stby_q]) begin
                        state_d = FT_FATAL;
                    end else begin
                        state_d = FT_DRAIN;
                        for (int unsigned k = 0; k < 4; k++) begin
                            if (new_active[k]) victim_d = FT_STBY_W'(k);
                        end
`ifdef CV32E40P_FT_ALU_ROTATE_EN
                        rot_d = 1'b0;
`endif
                    end
                end else if (new_fault[stby_q]) begin
                    state_d = FT_DEGRADED;
                end
`ifdef CV32E40P_FT_ALU_ROTATE_EN
                else if (cnt_zero && (mask_q == '0)) begin
                    state_d  = FT_DRAIN;
                    victim_d = stby_q + 2'd1;
                    rot_d    = 1'b1;
                end
`endif
            end
            FT_DRAIN: begin
                if (alu_ready_i) begin
                    state_d      = FT_WARMUP;
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(WARMUP_CYCLES);
                end
            end
            FT_WARMUP: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    // Faults that arrived during the drain/warm-up are judged
                    // against the post-swap active set, including this cycle's.
                    stby_d = victim_q;
                    if ((mask_d & post_used) != '0) begin
                        state_d = FT_FATAL;
                    end else begin
                        state_d = FT_DEGRADED;
`ifdef CV32E40P_FT_ALU_ROTATE_EN
                        if (rot_q && !mask_d[victim_q]) state_d = FT_NORMAL;
`endif
                    end
`ifdef CV32E40P_FT_ALU_ROTATE_EN
                    rot_d        = 1'b0;
                    cnt_dec      = 1'b0;
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(ROTATE_PERIOD);
`endif
                end
            end
            FT_DEGRADED: begin
                if (new_active != '0) state_d = FT_FATAL;
            end
            default: ;
        endcase

        sel_d    = ft_stby_to_sel(stby_d);
        used_d   = ft_stby_to_used(stby_d);
        clk_en_d = used_d;
        if (state_d == FT_WARMUP) clk_en_d = used_d | (4'b0001 << stby_d);
    end

    always_comb begin
        reconf_stall_o = (state_q == FT_DRAIN) || (state_q == FT_WARMUP);
        degraded_o     = (state_q == FT_DEGRADED) || (state_q == FT_FATAL);
        fatal_o        = (state_q == FT_FATAL);
        sel_mux_ex_o   = sel_q;
        used_alu_o     = used_q;
        clock_en_o     = clk_en_q;
        faulty_mask_o  = mask_q;
    end

endmodule

// File: tb/tb_cv32e40p_alu_ft_reconf_ctrl.sv
// Self-checking bench for cv32e40p_alu_ft_reconf_ctrl: directed scenarios plus
// randomized fault/ready traffic checked against a behavioural model.
module tb_cv32e40p_alu_ft_reconf_ctrl;

    localparam int unsigned TB_WARMUP = 2;
    localparam int unsigned TB_ROT    = 16;

    localparam int PH_NORMAL   = 0;
    localparam int PH_DRAIN    = 1;
    localparam int PH_WARMUP   = 2;
    localparam int PH_DEGRADED = 3;
    localparam int PH_FATAL    = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] faulty_pulse_i = '0;
    logic       alu_ready_i = 1'b1;
    logic [2:0] sel_mux_ex_o;
    logic [3:0] clock_en_o;
    logic [3:0] used_alu_o;
    logic [3:0] faulty_mask_o;
    logic       reconf_stall_o;
    logic       degraded_o;
    logic       fatal_o;

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model state
    int         m_phase;
    int         m_stby;
    int         m_victim;
    int         m_warm;
    int         m_rot_cnt;
    bit         m_rotating;
    logic [3:0] m_mask;

    cv32e40p_alu_ft_reconf_ctrl #(
        .WARMUP_CYCLES(TB_WARMUP),
        .ROTATE_PERIOD(TB_ROT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .faulty_pulse_i(faulty_pulse_i),
        .alu_ready_i   (alu_ready_i),
        .sel_mux_ex_o  (sel_mux_ex_o),
        .clock_en_o    (clock_en_o),
        .used_alu_o    (used_alu_o),
        .faulty_mask_o (faulty_mask_o),
        .reconf_stall_o(reconf_stall_o),
        .degraded_o    (degraded_o),
        .fatal_o       (fatal_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_used(input int stby);
        return 4'hF ^ (4'h1 << stby);
    endfunction

    task automatic model_reset();
        m_phase    = PH_NORMAL;
        m_stby     = 3;
        m_victim   = 3;
        m_warm     = 0;
        m_rot_cnt  = 0;
        m_rotating = 1'b0;
        m_mask     = '0;
    endtask

    task automatic model_step(input logic [3:0] p, input logic r);
        logic [3:0] nf;
        logic [3:0] act;
        logic [3:0] mask_after;
        nf  = p & ~m_mask;
        act = nf & m_used(m_stby);
        mask_after = m_mask | nf;
        case (m_phase)
            PH_NORMAL: begin
                if ($countones(act) >= 1 && $countones(nf) >= 2) begin
                    m_phase = PH_FATAL;
                end else if ($countones(act) == 1) begin
                    m_phase    = PH_DRAIN;
                    m_rotating = 1'b0;
                    for (int k = 0; k < 4; k++) if (act[k]) m_victim = k;
                end else if (nf[m_stby]) begin
                    m_phase = PH_DEGRADED;
                end else begin
`ifdef CV32E40P_FT_ALU_ROTATE_EN
                    if (m_rot_cnt == TB_ROT - 1) begin
                        m_rot_cnt = 0;
                        if (m_mask == '0) begin
                            m_phase    = PH_DRAIN;
                            m_victim   = (m_stby + 1) % 4;
                            m_rotating = 1'b1;
                        end
                    end else begin
                        m_rot_cnt++;
                    end
`endif
                end
            end
            PH_DRAIN: begin
                if (r) begin
                    m_phase = PH_WARMUP;
                    m_warm  = TB_WARMUP;
                end
            end
            PH_WARMUP: begin
                m_warm--;
                if (m_warm == 0) begin
                    m_stby = m_victim;
                    if ((mask_after & m_used(m_stby)) != '0) m_phase = PH_FATAL;
                    else if (m_rotating && !mask_after[m_stby]) m_phase = PH_NORMAL;
                    else m_phase = PH_DEGRADED;
                    m_rotating = 1'b0;
                    m_rot_cnt  = 0;
                end
            end
            PH_DEGRADED: begin
                if (act != '0) m_phase = PH_FATAL;
            end
            default: ;
        endcase
        m_mask = mask_after;
    endtask

    task automatic check_outputs();
        logic [2:0] s;
        logic [3:0] ce;
        for (int k = 0; k < 3; k++) s[k] = (m_stby != k);
        ce = m_used(m_stby) | ((m_phase == PH_WARMUP) ? (4'h1 << m_stby) : 4'h0);
        check_eq("sel", sel_mux_ex_o, s);
        check_eq("used", used_alu_o, m_used(m_stby));
        check_eq("clock_en", clock_en_o, ce);
        check_eq("mask", faulty_mask_o, m_mask);
        check_eq("stall", reconf_stall_o, (m_phase == PH_DRAIN || m_phase == PH_WARMUP));
        check_eq("degraded", degraded_o, (m_phase == PH_DEGRADED || m_phase == PH_FATAL));
        check_eq("fatal", fatal_o, (m_phase == PH_FATAL));
    endtask

    // Called at a falling edge; drives one cycle of inputs and checks the result.
    task automatic step(input logic [3:0] p, input logic r);
        faulty_pulse_i = p;
        alu_ready_i    = r;
        model_step(p, r);
        @(posedge clk);
        @(negedge clk);
        faulty_pulse_i = '0;
        check_outputs();
    endtask

    // Asserts reset between edges so the asynchronous clear is observed directly.
    task automatic do_reset();
        faulty_pulse_i = '0;
        alu_ready_i    = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int stalls;
        logic [3:0] p;
        model_reset();
        @(negedge clk);
        do_reset();
        check_eq("rst_sel", sel_mux_ex_o, 3'b111);
        check_eq("rst_used", used_alu_o, 4'b0111);
        check_eq("rst_clken", clock_en_o, 4'b0111);

        // single active fault, ready high: stall = WARMUP_CYCLES + 1
        stalls = 0;
        step(4'b0001, 1'b1);
        for (int i = 0; i < 8; i++) begin
            if (reconf_stall_o) stalls++;
            if (i == 1) check_eq("a_warm_clken", clock_en_o, 4'b1111);
            step(4'b0000, 1'b1);
        end
        check_eq("a_stall_len", stalls, TB_WARMUP + 1);
        check_eq("a_sel", sel_mux_ex_o, 3'b110);
        check_eq("a_used", used_alu_o, 4'b1110);
        check_eq("a_clken", clock_en_o, 4'b1110);
        check_eq("a_degraded", degraded_o, 1'b1);

        // second active fault after a swap: fatal, frozen, no stall
        step(4'b0100, 1'b1);
        step(4'b0000, 1'b1);
        check_eq("c_fatal", fatal_o, 1'b1);
        check_eq("c_sel", sel_mux_ex_o, 3'b110);
        check_eq("c_stall", reconf_stall_o, 1'b0);

        // fault while a multicycle op keeps ready low for 5 cycles
        do_reset();
        stalls = 0;
        step(4'b0010, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (reconf_stall_o) stalls++;
            step(4'b0000, 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            if (reconf_stall_o) stalls++;
            step(4'b0000, 1'b1);
        end
        check_eq("b_stall_len", stalls, 5 + TB_WARMUP + 1);
        check_eq("b_sel", sel_mux_ex_o, 3'b101);

        // double fault in one cycle: fatal without a swap
        do_reset();
        step(4'b0011, 1'b1);
        check_eq("d_fatal", fatal_o, 1'b1);
        check_eq("d_stall", reconf_stall_o, 1'b0);
        check_eq("d_sel", sel_mux_ex_o, 3'b111);

        // standby fault: degraded, repeated pulse ignored, then active fault -> fatal
        do_reset();
        step(4'b1000, 1'b1);
        step(4'b1000, 1'b1);
        check_eq("e_degraded", degraded_o, 1'b1);
        check_eq("e_fatal0", fatal_o, 1'b0);
        step(4'b0001, 1'b1);
        check_eq("e_fatal1", fatal_o, 1'b1);

        // new fault during drain lands in the post-swap active set
        do_reset();
        step(4'b0001, 1'b0);
        step(4'b0100, 1'b0);
        for (int i = 0; i < 6; i++) step(4'b0000, 1'b1);
        check_eq("f_fatal", fatal_o, 1'b1);

        // reset in the middle of a swap clears everything, including the mask
        do_reset();
        step(4'b0001, 1'b0);
        step(4'b0000, 1'b1);
        do_reset();
        check_eq("g_mask", faulty_mask_o, 4'b0000);

`ifdef CV32E40P_FT_ALU_ROTATE_EN
        do_reset();
        for (int i = 0; i < int'(TB_ROT + TB_WARMUP + 1); i++) step(4'b0000, 1'b1);
        check_eq("r_sel0", sel_mux_ex_o, 3'b110);
        check_eq("r_deg0", degraded_o, 1'b0);
        for (int i = 0; i < int'(TB_ROT + TB_WARMUP + 1); i++) step(4'b0000, 1'b1);
        check_eq("r_sel1", sel_mux_ex_o, 3'b101);
        step(4'b0001, 1'b1);
        for (int i = 0; i < 3 * int'(TB_ROT); i++) step(4'b0000, 1'b1);
        check_eq("r_sel_frozen", sel_mux_ex_o, 3'b110);
`endif

        // randomized episodes
        for (int ep = 0; ep < 25; ep++) begin
            do_reset();
            for (int c = 0; c < 70; c++) begin
                case ($urandom_range(0, 29))
                    0:       p = 4'h1 << $urandom_range(0, 3);
                    1:       p = 4'($urandom_range(0, 15));
                    default: p = 4'h0;
                endcase
                step(p, ($urandom_range(0, 3) != 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
